// File: rtl/text_term_pkg.sv
// Shared types and character constants for the text terminal controller.
package text_term_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } tt_state_e;

  // What the WRITE cycle does to the cursor once its (optional) write is issued.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_INC  = 2'd1,
    OP_NL   = 2'd2
  } tt_op_e;

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_BS    = 8'h08;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_term_clr.sv
// Fill-address counter: walks rows start_row..end_row, COLS cells each, one cell per step.
module text_term_clr #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [4:0] start_row,
  output logic [4:0] row,
  output logic [6:0] col,
  output logic       done
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [4:0] end_row;

  // Out of reset the range is the whole screen, so INIT needs no start pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row     <= 5'd0;
      col     <= 7'd0;
      end_row <= LAST_ROW;
    end else if (start) begin
      row     <= start_row;
      col     <= 7'd0;
      end_row <= start_row;
    end else if (step) begin
      if (col == LAST_COL) begin
        col <= 7'd0;
        row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
      end else begin
        col <= col + 7'd1;
      end
    end
  end

  assign done = step && (col == LAST_COL) && (row == end_row);

endmodule

// File: rtl/text_term_ctrl.sv
// Keyboard-to-character-RAM terminal: cursor, newline/scroll with row clearing, backspace.
module text_term_ctrl
  import text_term_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii,
  input  logic       ascii_valid,
  input  logic       key_release,
  output logic       in_ready,
  output logic       drop,
  output logic       vram_we,
  output logic [11:0] vram_addr,
  output logic [7:0] vram_data,
  output logic [4:0] top_row,
  output logic [4:0] cur_row,
  output logic [6:0] cur_col,
  output tt_state_e  state
);

  // Handshake: a strobe (ascii_valid) is consumed only in a cycle where in_ready
  // is high; a strobe seen while in_ready is low is lost and flagged on drop.

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  tt_op_e      op;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic [4:0]  line_cnt;
  logic [4:0]  nl_row;
  logic        accept;
  logic        fill;
  logic        clr_start;
  logic [4:0]  fill_row;
  logic [6:0]  fill_col;
  logic        fill_done;

  assign in_ready  = (state == IDLE);
  assign accept    = in_ready && ascii_valid && !key_release;
  assign nl_row    = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
  assign fill      = (state == INIT) || (state == CLEAR);
  assign clr_start = (state == WRITE) && (op == OP_NL);

  text_term_clr #(.COLS(COLS), .ROWS(ROWS)) u_clr (
    .clk       (clk),
    .reset     (reset),
    .start     (clr_start),
    .step      (fill),
    .start_row (nl_row),
    .row       (fill_row),
    .col       (fill_col),
    .done      (fill_done)
  );

  // CR also passes through WRITE (with no write) so every newline has the same latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      cur_row  <= 5'd0;
      cur_col  <= 7'd0;
      top_row  <= 5'd0;
      line_cnt <= 5'd0;
      op       <= OP_NONE;
      wr_addr  <= 12'd0;
      wr_data  <= 8'd0;
      wr_en    <= 1'b0;
    end else begin
      case (state)
        INIT: if (fill_done) state <= IDLE;
        IDLE: begin
          if (accept) begin
            if (is_printable(ascii)) begin
              wr_addr <= {cur_row, cur_col};
              wr_data <= ascii;
              wr_en   <= 1'b1;
              op      <= (cur_col == LAST_COL) ? OP_NL : OP_INC;
              state   <= WRITE;
            end else if (ascii == CHR_CR) begin
              wr_en <= 1'b0;
              op    <= OP_NL;
              state <= WRITE;
            end else if ((ascii == CHR_BS) && (cur_col != 7'd0)) begin
              cur_col <= cur_col - 7'd1;
              wr_addr <= {cur_row, cur_col - 7'd1};
              wr_data <= CHR_SPACE;
              wr_en   <= 1'b1;
              op      <= OP_NONE;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          state <= IDLE;
          case (op)
            OP_INC: cur_col <= cur_col + 7'd1;
            OP_NL: begin
              cur_col <= 7'd0;
              cur_row <= nl_row;
              if (line_cnt < LAST_ROW) line_cnt <= line_cnt + 5'd1;
              else top_row <= (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
              state <= CLEAR;
            end
            default: ;
          endcase
        end
        CLEAR: if (fill_done) state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  assign vram_we   = !reset && (fill || ((state == WRITE) && wr_en));
  assign vram_addr = fill ? {fill_row, fill_col} : wr_addr;
  assign vram_data = fill ? CHR_SPACE : wr_data;
  assign drop      = !reset && ascii_valid && !in_ready;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed bench for text_term_ctrl: cursor model plus a queue of expected RAM writes.
module tb_text_term_ctrl;
  import text_term_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ascii = 8'h00;
  logic        ascii_valid = 1'b0;
  logic        key_release = 1'b0;
  logic        in_ready, drop, vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [4:0]  top_row, cur_row;
  logic [6:0]  cur_col;
  tt_state_e   st;

  logic [19:0] exp_q[$];
  logic [19:0] exp_wr;
  int chk_cnt = 0;
  int pass_cnt = 0;
  int wr_cnt = 0;
  int m_row, m_col, m_top, m_lines;
  int lat, k;

  always #5 clk = ~clk;

  text_term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk         (clk),
    .reset       (reset),
    .ascii       (ascii),
    .ascii_valid (ascii_valid),
    .key_release (key_release),
    .in_ready    (in_ready),
    .drop        (drop),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .top_row     (top_row),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .state       (st)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      wr_cnt++;
      check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_wr = exp_q.pop_front();
        check("wr_addr_data", {12'd0, vram_addr, vram_data}, {12'd0, exp_wr});
      end
    end
  end

  task automatic push_wr(input int row, input int col, input logic [7:0] d);
    exp_q.push_back({5'(row), 7'(col), d});
  endtask

  task automatic model_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    if (m_lines < ROWS - 1) m_lines++;
    else m_top = (m_top + 1) % ROWS;
    for (int c = 0; c < COLS; c++) push_wr(m_row, c, 8'h20);
  endtask

  // Returns the expected number of negedges from the strobe to in_ready high.
  task automatic model_key(input logic [7:0] a, output int exp_lat);
    exp_lat = 1;
    if (a >= 8'h20 && a <= 8'h7E) begin
      push_wr(m_row, m_col, a);
      exp_lat = 2;
      if (m_col == COLS - 1) begin
        model_newline();
        exp_lat = 2 + COLS;
      end else m_col++;
    end else if (a == 8'h0D) begin
      model_newline();
      exp_lat = 2 + COLS;
    end else if (a == 8'h08 && m_col > 0) begin
      m_col--;
      push_wr(m_row, m_col, 8'h20);
      exp_lat = 2;
    end
  endtask

  task automatic drive_strobe(input logic [7:0] a, input logic rel);
    @(posedge clk); #1;
    check("rdy_before_strobe", 32'(in_ready), 32'd1);
    ascii = a; ascii_valid = 1'b1; key_release = rel;
    @(posedge clk); #1;
    ascii_valid = 1'b0; key_release = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_row"}, 32'(cur_row), 32'(m_row));
    check({tag, "_col"}, 32'(cur_col), 32'(m_col));
    check({tag, "_top"}, 32'(top_row), 32'(m_top));
    check({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [7:0] a);
    int exp_lat, n;
    model_key(a, exp_lat);
    drive_strobe(a, 1'b0);
    wait_ready(COLS + 10, n);
    check("latency", 32'(n), 32'(exp_lat));
    check_pos("send");
  endtask

  task automatic do_reset();
    int n;
    @(posedge clk); #1;
    reset = 1'b1;
    ascii_valid = 1'b1;
    @(negedge clk);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    check("rst_top", 32'(top_row), 32'd0);
    ascii_valid = 1'b0;
    exp_q.delete();
    m_row = 0; m_col = 0; m_top = 0; m_lines = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push_wr(r, c, 8'h20);
    wr_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(ROWS * COLS + 20, n);
    check("init_latency", 32'(n), 32'(ROWS * COLS + 1));
    check("init_wr_cnt", 32'(wr_cnt), 32'(ROWS * COLS));
    check_pos("init");
  endtask

  initial begin
    // Reset release and full INIT
    do_reset();

    // 'A': write visible the cycle after acceptance, ready again one cycle later
    model_key(8'h41, lat);
    drive_strobe(8'h41, 1'b0);
    @(negedge clk);
    check("A_we", 32'(vram_we), 32'd1);
    check("A_addr", 32'(vram_addr), 32'h000);
    check("A_data", 32'(vram_data), 32'h41);
    check("A_rdy_n1", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("A_rdy_n2", 32'(in_ready), 32'd1);
    check_pos("A");
    check("A_col", 32'(cur_col), 32'd1);

    // Fill the rest of row 0; the 80th char lands at col 79 and wraps
    for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32, 126)));
    check("wrap_row", 32'(cur_row), 32'd1);
    check("wrap_col", 32'(cur_col), 32'd0);

    // Backspace at col 0 is a no-op; at col 3 it blanks col 2
    send(8'h08);
    send(8'h78);
    send(8'h79);
    send(8'h7A);
    send(8'h08);
    check("bs_col", 32'(cur_col), 32'd2);

    // Codes outside the handled set
    send(8'h7F);
    send(8'h1B);
    send(8'h0A);

    // Key-release strobe in IDLE: ignored, no drop
    @(posedge clk); #1;
    ascii = 8'h51; ascii_valid = 1'b1; key_release = 1'b1;
    @(negedge clk);
    check("rel_drop", 32'(drop), 32'd0);
    check("rel_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    ascii_valid = 1'b0; key_release = 1'b0;
    @(negedge clk);
    check("rel_rdy_after", 32'(in_ready), 32'd1);
    check_pos("rel");

    // Strobe in the middle of CLEAR is dropped
    model_key(8'h0D, lat);
    drive_strobe(8'h0D, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    ascii = 8'h5A; ascii_valid = 1'b1;
    @(negedge clk);
    check("mid_drop", 32'(drop), 32'd1);
    check("mid_we", 32'(vram_we), 32'd1);
    @(posedge clk); #1;
    ascii_valid = 1'b0;
    @(negedge clk);
    check("mid_drop_end", 32'(drop), 32'd0);
    wait_ready(COLS + 10, k);
    check_pos("mid");

    // Strobe in the last CLEAR cycle is dropped too
    model_key(8'h0D, lat);
    drive_strobe(8'h0D, 1'b0);
    repeat (COLS) @(posedge clk);
    #1;
    ascii = 8'h5A; ascii_valid = 1'b1;
    @(negedge clk);
    check("last_drop", 32'(drop), 32'd1);
    check("last_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    ascii_valid = 1'b0;
    @(negedge clk);
    check("last_rdy_after", 32'(in_ready), 32'd1);
    check_pos("last");

    // Reset in the middle of a CLEAR aborts it and reruns INIT
    model_key(8'h0D, lat);
    drive_strobe(8'h0D, 1'b0);
    repeat (5) @(posedge clk);
    do_reset();

    // 30 CRs from (0,0): the 30th scrolls
    for (int i = 0; i < ROWS; i++) begin
      send(8'h0D);
      if (i == ROWS - 2) begin
        check("cr29_top", 32'(top_row), 32'd0);
        check("cr29_row", 32'(cur_row), 32'(ROWS - 1));
      end
    end
    check("cr30_top", 32'(top_row), 32'd1);
    check("cr30_row", 32'(cur_row), 32'd0);
    check("cr30_col", 32'(cur_col), 32'd0);

    // One more newline keeps scrolling
    send(8'h0D);
    check("cr31_top", 32'(top_row), 32'd2);
    send(8'h42);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", chk_cnt, pass_cnt);
    $fatal(1, "watchdog");
  end

endmodule
